// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                FSM state encoding, word-address offset and the address
//                legality check used when a request reaches its response.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Byte-address bit where the word index starts
    localparam int ADDR_LSB = 2;

    // Width of the latency down-counter (LATENCY up to 15)
    localparam int CNT_W = 4;

    // A request is illegal when it is not word aligned or its word index
    // lies beyond the stored depth.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input logic [31:0] depth_words);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:ADDR_LSB]};
        return (addr[ADDR_LSB-1:0] != '0) || (word_idx >= depth_words);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH_WORDS x 32 storage with a synchronous write port and
//                a combinational read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write port: one word per clock when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder for a pipeline MEM stage. Accepts one
//                load/store at a time, waits LATENCY cycles, then presents a
//                held response (data or error) until the pipeline consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q,  addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q,   err_d;

    // Request seen by the response logic: with zero latency the response is
    // formed on the acceptance edge, before the latch holds it.
    logic             cur_write;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic             enter_resp;
    logic             mem_we;
    logic [31:0]      mem_rdata;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cur_addr[ADDR_LSB +: AW]),
        .wdata (cur_wdata),
        .raddr (cur_addr[ADDR_LSB +: AW]),
        .rdata (mem_rdata)
    );

    // Select the live request in IDLE, the latched one afterwards
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
        cur_err = addr_error(cur_addr, 32'(DEPTH_WORDS));
    end

    // Next-state, counter, request latch and response formation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
        endcase

        // Commit the store and capture the response on the edge into RESP;
        // errored requests never touch storage and return zero data.
        if (enter_resp) begin
            mem_we  = cur_write & ~cur_err;
            err_d   = cur_err;
            rdata_d = (cur_write || cur_err) ? '0 : mem_rdata;
        end
    end

    // State and datapath registers; reset abandons any in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Instance A runs with
//                LATENCY=2, instance B with LATENCY=0. Expected responses come
//                from a reference memory model and flow through a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int L_A   = 2;
    localparam int L_B   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    // Reference model: applies a request to the model memory, returns expectation
    function automatic exp_t model(input bit which, input logic wr,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   idx;
        idx     = int'(addr[31:2]);
        e.rdata = '0;
        e.err   = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
        if (!e.err) begin
            if (wr) begin
                if (which) mem_b[idx] = wdata;
                else       mem_a[idx] = wdata;
            end else if (which) begin
                e.rdata = mem_b.exists(idx) ? mem_b[idx] : '0;
            end else begin
                e.rdata = mem_a.exists(idx) ? mem_a[idx] : '0;
            end
        end
        return e;
    endfunction

    // One full transaction with rsp_ready=1; entered and left at posedge+1
    task automatic do_txn(input bit which, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat,
                          output logic [31:0] rdata, output logic err);
        int guard = 0;
        rsp_ready = 1'b1;
        while (!(which ? req_ready_b : req_ready_a) && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        req_write = wr; req_addr = addr; req_wdata = wdata;
        if (which) req_valid_b = 1'b1;
        else       req_valid_a = 1'b1;
        exp_q.push_back(model(which, wr, addr, wdata));
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lat = 1;
        while (!(which ? rsp_valid_b : rsp_valid_a) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rdata = which ? rsp_rdata_b : rsp_rdata_a;
        err   = which ? rsp_err_b   : rsp_err_a;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid_a = 0; req_valid_b = 0; req_write = 0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_a: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                     req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a);
        end
        n_cmp++;
        if ({req_ready_b, rsp_valid_b, rsp_err_b, rsp_rdata_b} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_b: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                     req_ready_b, rsp_valid_b, rsp_err_b, rsp_rdata_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; exp_t e;
        do_txn(0, 1'b1, 32'h8, 32'hDEADBEEF, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== L_A + 1) begin n_bad++; $display("FAIL store_latency: got %0d want %0d", lat, L_A + 1); end
        n_cmp++;
        if ({rd, er} !== e) begin n_bad++; $display("FAIL store_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        do_txn(0, 1'b0, 32'h8, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== L_A + 1) begin n_bad++; $display("FAIL load_latency: got %0d want %0d", lat, L_A + 1); end
        n_cmp++;
        if ({rd, er} !== e) begin n_bad++; $display("FAIL load_rsp: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    endtask

    task automatic test_latency0();
        int lat; logic [31:0] rd; logic er; exp_t e;
        do_txn(1, 1'b1, 32'h0, 32'h12345678, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if ({rd, er, lat} !== {e, 32'(L_B + 1)}) begin
            n_bad++; $display("FAIL l0_preload: got %h/%b lat %0d want %h/%b lat %0d", rd, er, lat, e.rdata, e.err, L_B + 1);
        end
        do_txn(1, 1'b0, 32'h0, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if (lat !== L_B + 1) begin n_bad++; $display("FAIL l0_latency: got %0d want %0d", lat, L_B + 1); end
        n_cmp++;
        if ({rd, er} !== e) begin n_bad++; $display("FAIL l0_load: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er; exp_t e;
        logic [31:0] addrs [4] = '{32'h4, 32'h6, 32'h400, 32'h4};
        logic        wrs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] wds   [4] = '{32'h11111111, 32'h55555555, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            do_txn(0, wrs[i], addrs[i], wds[i], lat, rd, er);
            e = exp_q.pop_front();
            n_cmp++;
            if ({rd, er} !== e) begin
                n_bad++; $display("FAIL err_case%0d: got %h/%b want %h/%b", i, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0; logic [31:0] hold_rd; logic hold_er; exp_t e;
        rsp_ready = 1'b0;
        req_write = 1'b0; req_addr = 32'h8; req_valid_a = 1'b1;
        exp_q.push_back(model(0, 1'b0, 32'h8, 32'h0));
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        while (!rsp_valid_a && guard < 50) begin @(posedge clk); #1; guard++; end
        hold_rd = rsp_rdata_a; hold_er = rsp_err_a;
        e = exp_q.pop_front();
        n_cmp++;
        if (!rsp_valid_a || {hold_rd, hold_er} !== e) begin
            n_bad++; $display("FAIL bp_first: got vld=%b %h/%b want 1 %h/%b", rsp_valid_a, hold_rd, hold_er, e.rdata, e.err);
        end
        req_valid_a = 1'b1; req_addr = 32'h4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rsp_valid_a, req_ready_a, rsp_rdata_a, rsp_err_a} !== {1'b1, 1'b0, hold_rd, hold_er}) begin
                n_bad++; $display("FAIL bp_hold%0d: got vld=%b rdy=%b %h/%b want 1 0 %h/%b",
                                  i, rsp_valid_a, req_ready_a, rsp_rdata_a, rsp_err_a, hold_rd, hold_er);
            end
        end
        req_valid_a = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({rsp_valid_a, req_ready_a, rsp_rdata_a, rsp_err_a} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL bp_release: got vld=%b rdy=%b %h/%b want 0 1 0/0",
                              rsp_valid_a, req_ready_a, rsp_rdata_a, rsp_err_a);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; exp_t e;
        do_txn(0, 1'b1, 32'h10, 32'h0BADC0DE, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if ({rd, er} !== e) begin n_bad++; $display("FAIL rm_prior: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
        // store that will be abandoned: no model update
        req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        n_cmp++;
        if (req_ready_a !== 1'b0) begin n_bad++; $display("FAIL rm_in_wait: got rdy=%b want 0", req_ready_a); end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL rm_async: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
                              req_ready_a, rsp_valid_a, rsp_err_a, rsp_rdata_a);
        end
        #3 rst = 1'b1;
        @(posedge clk); #1;
        do_txn(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
        e = exp_q.pop_front();
        n_cmp++;
        if ({rd, er} !== e) begin n_bad++; $display("FAIL rm_after: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [5] = '{32'h8, 32'h4, 32'h10, 32'h3, 32'h8};
        int idx = 0, done = 0, cyc = 0, last_acc = 0;
        bit acc;
        exp_t e;
        rsp_ready = 1'b1; req_write = 1'b0; req_addr = addrs[0]; req_valid_a = 1'b1;
        while (done < 5 && cyc < 200) begin
            @(negedge clk);
            acc = req_valid_a && req_ready_a;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (idx > 0) begin
                    n_cmp++;
                    if (cyc - last_acc < L_A + 2) begin
                        n_bad++; $display("FAIL b2b_gap%0d: got %0d want >= %0d", idx, cyc - last_acc, L_A + 2);
                    end
                end
                last_acc = cyc;
                exp_q.push_back(model(0, 1'b0, addrs[idx], 32'h0));
                idx++;
                if (idx < 5) req_addr = addrs[idx];
                else         req_valid_a = 1'b0;
            end
            if (rsp_valid_a) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra: got rsp %h/%b want none", rsp_rdata_a, rsp_err_a);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_rdata_a, rsp_err_a} !== e) begin
                        n_bad++; $display("FAIL b2b_rsp%0d: got %h/%b want %h/%b", done, rsp_rdata_a, rsp_err_a, e.rdata, e.err);
                    end
                end
                done++;
            end
        end
        req_valid_a = 1'b0;
        n_cmp++;
        if (done != 5) begin n_bad++; $display("FAIL b2b_timeout: got %0d responses want 5", done); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_latency0();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words stored.
REQ-002 SHALL provide parameter LATENCY, default 2, meaning the wait cycles between request acceptance and response (legal 0..15).
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL provide port req_valid, input, 1 bit: the pipeline MEM stage presents a load or store.
REQ-006 SHALL provide port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL provide port req_addr, input, 32 bits: byte address (the EX/MEM ALU result).
REQ-008 SHALL provide port req_wdata, input, 32 bits: store data.
REQ-009 SHALL provide port req_ready, output, 1 bit: the responder can accept a request.
REQ-010 SHALL provide port rsp_valid, output, 1 bit: the response is present.
REQ-011 SHALL provide port rsp_ready, input, 1 bit: the pipeline consumes the response.
REQ-012 SHALL provide port rsp_rdata, output, 32 bits: load data; 0 for stores and errors.
REQ-013 SHALL provide port rsp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a clock edge with req_valid & req_ready, then:
- latch write, address and wdata;
- go to WAIT if LATENCY>0, else to RESP.
REQ-017 SHALL count LATENCY cycles in WAIT with a 4-bit counter loaded with LATENCY-1 at acceptance, and move to RESP on the edge where the counter is 0.
REQ-018 SHALL perform the following on the edge entering RESP:
- commit the write;
- register rsp_rdata from mem[addr[31:2]];
- register rsp_err.
REQ-019 SHALL assert rsp_valid exactly LATENCY+1 cycles after the acceptance edge.
REQ-020 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid & rsp_ready, then return to IDLE.
REQ-021 SHALL not assert req_ready in the cycle the response is consumed; the next request is accepted one cycle later at the earliest.
REQ-022 SHALL treat a request as an error when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; an error request writes nothing and returns rsp_rdata=0, rsp_err=1.
REQ-023 SHALL return rsp_rdata=0 and rsp_err=0 for a legal store.
REQ-024 SHALL deassert rsp_valid, rsp_rdata and rsp_err outside RESP (rsp_valid=0, rsp_rdata=0, rsp_err=0).
REQ-025 SHALL ignore req_* inputs in WAIT and RESP; changes to them do not affect the latched request.
REQ-026 SHALL return the newly written data for a load that follows a store to the same word.

Reset
REQ-027 SHALL on rst=0 immediately force the following, independent of clk:
- state to IDLE;
- counter to 0;
- req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 SHALL abandon an in-flight request when rst asserts in WAIT; its write is not committed.
REQ-029 SHALL not clear storage contents on reset.

Structure
REQ-030 SHALL place the state enum (IDLE/WAIT/RESP) and an ADDR_LSB=2 constant in shared package dmem_pkg.
REQ-031 SHALL instantiate one sub-module dmem_array (DEPTH_WORDS x 32, synchronous write, combinational read); the FSM, counter and error check stay in dmem_responder.

Verification
REQ-032 SHALL cover store then load, with LATENCY=2:
- stimulus: store addr 0x8, wdata 0xDEADBEEF; then load addr 0x8;
- required: rsp_valid 3 cycles after each acceptance, load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-033 SHALL cover LATENCY=0:
- stimulus: load addr 0x0 after reset-free preload of 0x12345678;
- required: rsp_valid on the cycle after acceptance, rsp_rdata=0x12345678.
REQ-034 SHALL cover misaligned and out-of-range errors:
- stimulus: store addr 0x6; then load addr 0x400 with DEPTH_WORDS=256;
- required: both give rsp_err=1, rsp_rdata=0, and mem[1] is unchanged.
REQ-035 SHALL cover backpressure:
- stimulus: rsp_ready held 0 for 5 cycles;
- required: rsp_valid/rsp_rdata held constant, req_ready=0 throughout, IDLE entered one edge after rsp_ready=1.
REQ-036 SHALL cover reset mid-operation:
- stimulus: rst=0 asserted in WAIT of a store of 0xCAFEF00D to 0x10;
- required: outputs go to reset values without a clock edge, and a later load of 0x10 returns the prior contents.
REQ-037 SHALL cover back-to-back requests:
- stimulus: req_valid held high with rsp_ready=1;
- required: acceptances occur no closer than LATENCY+2 cycles apart, and each response matches its own request.
